nios_rom_arbiter: RTL and testbench
===================================

# nios_rom_arbiter

Two-port arbiter sharing the single-port 8192×32 on-chip program/data memory between the Nios instruction/data master (m0) and the pixel-frame fetch engine (m1). It sits between both Avalon-MM masters and the memory's s1 slave port. It grants at most one access per cycle and gives m1 bounded priority for real-time LED refresh. It returns read data with a one-cycle `readdatavalid` to the granted requester.

## Interface
- `ADDR_W`, 13, word address width.
- `DATA_W`, 32, data width.
- `BURST_MAX`, 4, max consecutive contended m1 grants before m0 is served; legal range ≥1.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `mN_read`, `mN_write` (N=0,1)  in  1  request strobes, held until `mN_waitrequest`=0.
- `mN_address`  in  ADDR_W  word address.
- `mN_byteenable`  in  DATA_W/8  byte lanes.
- `mN_writedata`  in  DATA_W  write data.
- `mN_debugaccess`  in  1  debug-write qualifier.
- `mN_waitrequest`  out  1  stall.
- `mN_readdata`  out  DATA_W  read data.
- `mN_readdatavalid`  out  1  read data qualifier.
- `mem_address`, `mem_byteenable`, `mem_writedata`  out  to memory.
- `mem_chipselect`, `mem_write`, `mem_debugaccess`  out  1  to memory.
- `mem_clken`  out  1  memory clock enable.
- `mem_readdata`  in  DATA_W  memory output; valid one cycle after address.
- `wr_drop`  out  1  sticky: a write was accepted but discarded.

## Operation
- A request is `mN_read | mN_write`. If both strobes are high, the request is treated as a write.
- Grant is combinational from the current requests plus registered `burst_cnt`:
  - one requester → it wins.
  - both, `burst_cnt` < BURST_MAX → m1 wins.
  - both, `burst_cnt` == BURST_MAX → m0 wins.
- `burst_cnt` (width clog2(BURST_MAX+1)):
  - +1 on each m1 grant while m0 requests.
  - cleared when m0 is granted or m0 is not requesting.
  - saturates at BURST_MAX.
- `mN_waitrequest` = reset | (request & ~grantN). An idle master sees 0 outside reset.
- Memory command in the grant cycle:
  - mem_* = granted master's fields.
  - `mem_chipselect`=1.
  - `mem_write`=write & write-allowed.
  - With no grant: `mem_chipselect`=0, `mem_write`=0, address/data hold the previous value (don't care).
- `mem_clken`=1 always.
- Read return:
  - Register `rd_owner[1:0]` captures (read grant, master) each cycle.
  - Next cycle: `mN_readdatavalid`=`rd_owner` matches N.
  - `mN_readdata`=`mem_readdata` (pass-through, both ports).
- Reset (sampled at `clk` edge) clears `burst_cnt`, `rd_owner`, `wr_drop`. While `reset`=1: no grants, all waitrequest=1, `mem_chipselect`=0.

## Timing
- Grant/command latency: 0 cycles (same cycle as request).
- Read data latency: exactly 1 cycle after grant. Throughput is one access per cycle, with no bubbles between back-to-back reads from either or alternating masters.
- Reset values: `mN_readdatavalid`=0, `wr_drop`=0, `mem_chipselect`=0, `mem_write`=0, `mN_waitrequest`=1 during reset, `mem_clken`=1.
- Reset asserted the cycle after a read grant: that read's `readdatavalid` is suppressed (`rd_owner` cleared).
- A write completes in its grant cycle; no response phase.
- Simultaneous read from one master and write from the other: arbitration as above. The read returns memory contents per memory read-during-write = DONT_CARE only for the same address; otherwise the stored data.

## Configuration
- `NIOS_ROM_ARB_WRITE_EN` defined:
  - write-allowed = `mN_debugaccess`.
  - `mem_debugaccess` = granted master's `mN_debugaccess`.
  - A write without debugaccess is accepted, not stored, and sets `wr_drop`.
- Undefined:
  - write-allowed = 0.
  - `mem_debugaccess`=0.
  - Every granted write is accepted (waitrequest drops), `mem_write`=0, and `wr_drop` sets the following cycle.

## Test plan
- Reset 2 cycles with m0 and m1 both reading → both waitrequest=1, `mem_chipselect`=0, readdatavalid=0. First post-reset cycle grants m1.
- m0 read 0x0010 alone, memory model 0x0010=0xCAFEF00D → `mem_chipselect`=1 same cycle, `m0_readdatavalid`=1 with 0xCAFEF00D next cycle, `m1_readdatavalid`=0.
- BURST_MAX=4, both reading continuously → grant sequence m1,m1,m1,m1,m0,m1,m1,m1,m1,m0; readdatavalid follows with 1-cycle lag; no idle cycles.
- m1 reads 0x0000–0x0007 back-to-back → 8 consecutive `m1_readdatavalid` cycles with matching data.
- m0 writes 0xDEADBEEF to 0x1FFF, be=0xF, debugaccess=1, then reads 0x1FFF:
  - with macro → reads 0xDEADBEEF, `wr_drop`=0.
  - without macro → `mem_write`=0, old value read, `wr_drop`=1.
- m0 read granted, `reset` asserted next cycle → no `m0_readdatavalid`, `burst_cnt`=0 afterwards.

Source files
------------

// File: rtl/nios_rom_arbiter_if.sv
// One Avalon-MM requester of the shared program memory: command strobes in, stall and read return out.
`timescale 1ns/1ps
interface nios_rom_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic                read;
    logic                write;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                debugaccess;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output read, write, address, byteenable, writedata, debugaccess,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, write, address, byteenable, writedata, debugaccess,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios_rom_arbiter.sv
// Shares one single-port memory between m0 (Nios) and m1 (pixel fetch); grant in the request cycle, read data 1 cycle later,
// losers stall on waitrequest and m0 is served after BURST_MAX contended m1 wins. NIOS_ROM_ARB_WRITE_EN enables debug writes.
`timescale 1ns/1ps
module nios_rom_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    nios_rom_arbiter_if.slave   m0,
    nios_rom_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_debugaccess,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                wr_drop
);
    localparam int              CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    logic                req0, req1, gnt0, gnt1, gnt;
    logic                sel_wr, sel_dbg, wr_ok;
    logic [CNT_W-1:0]    burst_cnt_d, burst_cnt_q;
    logic [1:0]          rd_owner_d, rd_owner_q;
    logic                wr_drop_d, wr_drop_q;
    logic [ADDR_W-1:0]   addr_hold_d, addr_hold_q;
    logic [DATA_W/8-1:0] be_hold_d, be_hold_q;
    logic [DATA_W-1:0]   wdata_hold_d, wdata_hold_q;

    always_comb begin
        req0 = m0.read | m0.write;
        req1 = m1.read | m1.write;
        gnt1 = ~reset & req1 & (~req0 | (burst_cnt_q < CNT_MAX));
        gnt0 = ~reset & req0 & ~gnt1;
        gnt  = gnt0 | gnt1;

        // write strobe dominates read when a master raises both
        sel_wr  = gnt1 ? m1.write       : m0.write;
        sel_dbg = gnt1 ? m1.debugaccess : m0.debugaccess;
`ifdef NIOS_ROM_ARB_WRITE_EN
        wr_ok           = sel_dbg;
        mem_debugaccess = gnt & sel_dbg;
`else
        wr_ok           = sel_dbg & 1'b0;
        mem_debugaccess = 1'b0;
`endif
        mem_chipselect = gnt;
        mem_write      = gnt & sel_wr & wr_ok;
        mem_clken      = 1'b1;

        mem_address    = addr_hold_q;
        mem_byteenable = be_hold_q;
        mem_writedata  = wdata_hold_q;
        if (gnt1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
        end else if (gnt0) begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_writedata  = m0.writedata;
        end
        addr_hold_d  = mem_address;
        be_hold_d    = mem_byteenable;
        wdata_hold_d = mem_writedata;

        burst_cnt_d = burst_cnt_q;
        if (~req0 | gnt0) begin
            burst_cnt_d = '0;
        end else if (gnt1 && burst_cnt_q < CNT_MAX) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end

        rd_owner_d = {gnt & ~sel_wr, gnt1};
        wr_drop_d  = wr_drop_q | (gnt & sel_wr & ~wr_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_q <= '0;
            rd_owner_q  <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            rd_owner_q  <= rd_owner_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_hold_q  <= addr_hold_d;
        be_hold_q    <= be_hold_d;
        wdata_hold_q <= wdata_hold_d;
    end

    // readdatavalid is gated by reset so a read granted just before reset never returns
    assign m0.waitrequest   = reset | (req0 & ~gnt0);
    assign m1.waitrequest   = reset | (req1 & ~gnt1);
    assign m0.readdatavalid = ~reset & rd_owner_q[1] & ~rd_owner_q[0];
    assign m1.readdatavalid = ~reset & rd_owner_q[1] &  rd_owner_q[0];
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign wr_drop          = wr_drop_q;
endmodule

// File: tb/tb_nios_rom_arbiter.sv
// Randomized and directed bench for nios_rom_arbiter against a cycle-level reference of the arbitration rules.
`timescale 1ns/1ps
module tb_nios_rom_arbiter;
    localparam int BURST_MAX = 4;
`ifdef NIOS_ROM_ARB_WRITE_EN
    localparam bit ALLOW = 1'b1;
`else
    localparam bit ALLOW = 1'b0;
`endif

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        dbg;
    } req_t;

    logic        clk;
    logic        reset;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [31:0] mem_readdata;
    logic        wr_drop;

    nios_rom_arbiter_if #(.ADDR_W(13), .DATA_W(32)) m0_if ();
    nios_rom_arbiter_if #(.ADDR_W(13), .DATA_W(32)) m1_if ();

    nios_rom_arbiter #(.ADDR_W(13), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .m0              (m0_if),
        .m1              (m1_if),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_debugaccess (mem_debugaccess),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata),
        .wr_drop         (wr_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory with registered read port
    logic [31:0] mem [8192];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    int          n_vec, n_bad;
    int          streak;
    bit          exp_drop;
    bit   [1:0]  pend_v;
    logic [31:0] pend_d [2];
    logic [31:0] shadow [8192];
    bit          og0, og1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic req_t rq(input bit rd, input bit wr, input logic [12:0] a,
                                input logic [31:0] d = 32'h0, input bit dbg = 1'b1);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.be = 4'hF; r.data = d; r.dbg = dbg;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int   k;
        k      = $urandom_range(0, 7);
        r.rd   = (k >= 2 && k <= 5) || k == 7;
        r.wr   = (k >= 6);
        r.addr = ($urandom_range(0, 1) == 1) ? 13'(13'h1FF0 + $urandom_range(0, 15))
                                             : 13'($urandom_range(0, 31));
        r.be   = 4'($urandom_range(1, 15));
        r.data = $urandom;
        r.dbg  = ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    // Entered just after a rising edge: drive, check mid-cycle, update the reference, advance one cycle.
    task automatic step(input bit rst, input req_t q0, input req_t q1);
        bit   r0, r1, e0, e1, ok;
        req_t g;
        reset               = rst;
        m0_if.read          = q0.rd;  m0_if.write     = q0.wr;
        m0_if.address       = q0.addr; m0_if.byteenable = q0.be;
        m0_if.writedata     = q0.data; m0_if.debugaccess = q0.dbg;
        m1_if.read          = q1.rd;  m1_if.write     = q1.wr;
        m1_if.address       = q1.addr; m1_if.byteenable = q1.be;
        m1_if.writedata     = q1.data; m1_if.debugaccess = q1.dbg;
        #2;
        chk("m0_rdv", m0_if.readdatavalid, pend_v[0] & !rst);
        chk("m1_rdv", m1_if.readdatavalid, pend_v[1] & !rst);
        if (pend_v[0] && !rst) chk("m0_rdata", m0_if.readdata, pend_d[0]);
        if (pend_v[1] && !rst) chk("m1_rdata", m1_if.readdata, pend_d[1]);
        chk("wr_drop", wr_drop, exp_drop);
        chk("mem_clken", mem_clken, 1);

        // m0 wins when m1 is silent or after m1 has beaten it BURST_MAX times running
        r0 = q0.rd | q0.wr;
        r1 = q1.rd | q1.wr;
        e0 = !rst && r0 && (!r1 || streak == BURST_MAX);
        e1 = !rst && r1 && !e0;
        chk("m0_wait", m0_if.waitrequest, rst || (r0 && !e0));
        chk("m1_wait", m1_if.waitrequest, rst || (r1 && !e1));
        chk("mem_cs", mem_chipselect, e0 || e1);
        og0 = r0 && !m0_if.waitrequest;
        og1 = r1 && !m1_if.waitrequest;

        pend_v = 2'b00;
        if (e0 || e1) begin
            g  = e1 ? q1 : q0;
            ok = ALLOW && g.wr && g.dbg;
            chk("mem_addr", mem_address, g.addr);
            chk("mem_write", mem_write, ok);
            chk("mem_dbg", mem_debugaccess, ALLOW && g.dbg);
            if (ok) begin
                chk("mem_wdata", mem_writedata, g.data);
                chk("mem_be", mem_byteenable, g.be);
                for (int b = 0; b < 4; b++)
                    if (g.be[b]) shadow[g.addr][8*b +: 8] = g.data[8*b +: 8];
            end else if (g.wr) begin
                exp_drop = 1'b1;
            end else begin
                pend_v[e1] = 1'b1;
                pend_d[e1] = shadow[g.addr];
            end
        end else begin
            chk("mem_write_idle", mem_write, 0);
        end

        if (rst || !r0 || e0) streak = 0;
        else                  streak++;
        if (rst) exp_drop = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_t idle, c0, c1;
        int   a0, a1;
        n_vec = 0; n_bad = 0; streak = 0; exp_drop = 1'b0; pend_v = 2'b00;
        idle = rq(0, 0, 13'h0);
        for (int i = 0; i < 8192; i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        mem[16]    = 32'hCAFEF00D;
        shadow[16] = 32'hCAFEF00D;
        reset = 1'b1;
        m0_if.read = 0; m0_if.write = 0; m0_if.address = '0; m0_if.byteenable = '0;
        m0_if.writedata = '0; m0_if.debugaccess = 0;
        m1_if.read = 0; m1_if.write = 0; m1_if.address = '0; m1_if.byteenable = '0;
        m1_if.writedata = '0; m1_if.debugaccess = 0;
        @(posedge clk);
        #1;

        // reset held with both masters reading, then contended reads
        step(1, rq(1, 0, 13'h100), rq(1, 0, 13'h200));
        step(1, rq(1, 0, 13'h100), rq(1, 0, 13'h200));
        a0 = 0; a1 = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, rq(1, 0, 13'(13'h100 + a0)), rq(1, 0, 13'(13'h200 + a1)));
            chk("burst_seq_m1", og1, (i % 5) != 4);
            if (og0) a0++;
            if (og1) a1++;
        end
        step(0, idle, idle);

        // lone m0 read
        step(0, rq(1, 0, 13'h0010), idle);
        chk("cafe_rdv", m0_if.readdatavalid, 1);
        chk("cafe_data", m0_if.readdata, 32'hCAFEF00D);
        chk("cafe_m1_rdv", m1_if.readdatavalid, 0);
        step(0, idle, idle);

        // m1 streaming 8 words
        for (int i = 0; i < 8; i++) step(0, idle, rq(1, 0, 13'(i)));
        step(0, idle, idle);

        // debug write then read back at top address
        step(0, rq(0, 1, 13'h1FFF, 32'hDEADBEEF, 1), idle);
        step(0, rq(1, 0, 13'h1FFF), idle);
        chk("wb_data", m0_if.readdata, ALLOW ? 32'hDEADBEEF : init_val(13'h1FFF));
        chk("wb_drop", wr_drop, !ALLOW);
        step(0, idle, idle);

        // reset right after a read grant swallows its return
        step(0, rq(1, 0, 13'h0010), idle);
        step(1, idle, idle);
        chk("rst_abort_rdv", m0_if.readdatavalid, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, rq(1, 0, 13'h20), rq(1, 0, 13'(13'h40 + i)));
            chk("post_rst_m1", og1, i != 4);
        end
        step(0, idle, idle);

        // random traffic; a master holds its request until it is accepted
        c0 = idle; c1 = idle;
        og0 = 1'b0; og1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!(c0.rd || c0.wr) || og0) c0 = rnd_req();
            if (!(c1.rd || c1.wr) || og1) c1 = rnd_req();
            step($urandom_range(0, 99) == 0, c0, c1);
        end
        step(0, idle, idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
